sdram_traffic_gen: RTL
======================

// Module: sdram_traffic_gen
// PURPOSE
// - Synthesisable self-checking traffic generator for the sdram_ctrl user port.
// - Writes NUM_WORDS words from BASE_ADDR, then reads them back and compares.
// - Drives the wreq/wgnt and rreq/rgnt handshakes; tracks pipelined read returns.
// - Sits beside sdram_ctrl as on-chip BIST and as a parametrised bench stimulus source.
// PARAMETERS
// - AW         24         address width of waddr/raddr
// - DW         16         data width, legal range 8..32
// - NUM_WORDS  256        words per pass, >=1
// - BASE_ADDR  24'h0      first address (AW bits)
// - RD_LAT     4          cycles from rgnt to the matching rdata, >=1
// - SEED       32'hACE1   LFSR load value, must be nonzero
// PORTS
// - clk            in   1    system clock
// - rst_n          in   1    synchronous active-low reset
// - start          in   1    single-cycle pulse that starts a pass
// - mode           in   1    0 = incrementing data, 1 = LFSR data; sampled at start
// - busy           out  1    pass in progress
// - done           out  1    pass complete; held until next accepted start
// - pass           out  1    done && err_cnt==0
// - err_cnt        out  16   mismatch count, saturates at 16'hFFFF
// - wreq/wgnt      out/in 1  write request / grant
// - waddr/wdata    out  AW/DW  write address / data
// - rreq/rgnt      out/in 1  read request / grant
// - raddr          out  AW   read address
// - rdata          in   DW   read data, valid RD_LAT cycles after rgnt
// BEHAVIOUR
// - One clock (clk); reset synchronous, active-low (rst_n). Everything changes on posedge clk.
// - Reset values: all outputs 0; FSM IDLE; read tracking pipe empty.
// - FSM states:
//   - IDLE: start -> WRITE; busy=1; clear done and err_cnt; index=0; LFSR=SEED.
//   - WRITE: wreq=1, waddr=BASE_ADDR+index mod 2^AW, wdata=pattern(index).
//     - A transfer happens on the cycle with wreq&&wgnt.
//     - On a transfer: index++ and LFSR advances; the next word is presented the following cycle.
//     - After the last grant -> READ; index=0; LFSR reloaded with SEED.
//   - READ: rreq=1, same address rule. On each rreq&&rgnt, push {valid, expected} into an RD_LAT-deep shift pipe.
//     - After the last grant -> DRAIN with rreq=0.
//   - DRAIN: wait until the pipe is empty -> DONE.
//   - DONE: done=1, busy=0; start -> WRITE (restart).
// - Address/data are held stable while the request is asserted and ungranted.
// - Grants arriving while the matching req=0 are ignored.
// - Pattern:
//   - mode0: data = index zero-extended or truncated to DW.
//   - mode1: 32-bit Galois LFSR, poly 0x80200003; data = lfsr[DW-1:0]; advances once per granted word.
// - Compare: when the pipe tail is valid, rdata!=expected increments err_cnt (saturating).
// - Latency: start at cycle t -> wreq=1 at t+1. Last compare at cycle c -> done=1 at c+1.
// - start while busy is ignored. wreq and rreq are never high together.
// - rst_n low mid-pass aborts the pass, empties the pipe and clears the counters.
// CONFIGURATION
// - SDRAM_TG_ERRLOG_EN defined: adds outputs err_addr[AW], err_exp[DW], err_act[DW].
//   - These capture the address, expected and actual data of the first mismatch in the pass.
//   - They reset to 0 and are cleared on an accepted start.
// - SDRAM_TG_ERRLOG_EN undefined: those ports and registers are absent; everything else is identical.
// TESTING
// - NUM_WORDS=4, mode0, grants tied high, rdata echoes memory:
//   - waddr 0..3 / wdata 0..3, then raddr 0..3.
//   - Result: done=1, pass=1, err_cnt=0.
// - wgnt held low 10 cycles on word 1:
//   - waddr=1 and wdata=1 stay stable with wreq=1 throughout.
//   - Pass completes, pass=1.
// - Model corrupts rdata of word 2 (XOR 16'h0001):
//   - err_cnt=1, pass=0.
//   - With SDRAM_TG_ERRLOG_EN: err_addr=2, err_exp=2, err_act=3.
// - BASE_ADDR=24'hFFFFFE, NUM_WORDS=4: waddr sequence FFFFFE, FFFFFF, 000000, 000001.
// - mode1, SEED=32'hACE1, DW=16:
//   - First wdata=16'hACE1; readback matches, pass=1.
//   - start pulsed mid-pass is ignored.
// - rst_n low after 2 write grants:
//   - All outputs 0 next cycle.
//   - A new start rewrites from BASE_ADDR with err_cnt=0.

Source files
------------

// File: rtl/sdram_traffic_gen.sv
// Self-checking write/read-back traffic generator for the sdram_ctrl user port.
// Define SDRAM_TG_ERRLOG_EN to add the first-mismatch log outputs err_addr/err_exp/err_act.
module sdram_traffic_gen #(
  parameter int              AW        = 24,
  parameter int              DW        = 16,
  parameter int              NUM_WORDS = 256,
  parameter logic [AW-1:0]   BASE_ADDR = '0,
  parameter int              RD_LAT    = 4,
  parameter logic [31:0]     SEED      = 32'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_cnt,
`ifdef SDRAM_TG_ERRLOG_EN
  output logic [AW-1:0] err_addr,
  output logic [DW-1:0] err_exp,
  output logic [DW-1:0] err_act,
`endif
  output logic          wreq,
  input  logic          wgnt,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          rreq,
  input  logic          rgnt,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata
);

  localparam logic [31:0] POLY     = 32'h80200003;
  localparam logic [31:0] LAST_IDX = 32'(NUM_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
  endfunction

  function automatic logic [DW-1:0] pattern(input logic m, input logic [31:0] i,
                                            input logic [31:0] l);
    pattern = m ? l[DW-1:0] : i[DW-1:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    sat_inc = (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t               state;
  logic                 mode_r;
  logic [31:0]          idx;
  logic [31:0]          lfsr;
  logic [DW-1:0]        rexp;

  logic [RD_LAT-1:0]    vld_pipe;
  logic [DW-1:0]        exp_pipe [RD_LAT];
`ifdef SDRAM_TG_ERRLOG_EN
  logic [AW-1:0]        addr_pipe [RD_LAT];
`endif

  logic [31:0]          idx_nxt;
  logic [31:0]          lfsr_nxt;
  logic [DW-1:0]        data_nxt;
  logic                 w_xfer;
  logic                 r_xfer;
  logic                 last_word;
  logic                 miscmp;
  logic                 head_busy;

  assign idx_nxt   = idx + 32'd1;
  assign lfsr_nxt  = lfsr_step(lfsr);
  assign data_nxt  = pattern(mode_r, idx_nxt, lfsr_nxt);
  assign w_xfer    = wreq && wgnt;
  assign r_xfer    = rreq && rgnt;
  assign last_word = (idx == LAST_IDX);
  assign miscmp    = vld_pipe[RD_LAT-1] && (rdata != exp_pipe[RD_LAT-1]);
  assign pass      = done && (err_cnt == 16'd0);

  // Anything still ahead of the tail means more read data is outstanding.
  always_comb begin
    head_busy = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) head_busy = head_busy | vld_pipe[i];
  end

  // Read-return tracking: one slot per cycle of controller read latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= r_xfer;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    exp_pipe[0] <= rexp;
    for (int i = 1; i < RD_LAT; i++) exp_pipe[i] <= exp_pipe[i-1];
`ifdef SDRAM_TG_ERRLOG_EN
    addr_pipe[0] <= raddr;
    for (int i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
`endif
  end

  // Control FSM, error counter and request outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_cnt  <= '0;
      wreq     <= 1'b0;
      rreq     <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      raddr    <= '0;
      mode_r   <= 1'b0;
      idx      <= '0;
      lfsr     <= '0;
      rexp     <= '0;
`ifdef SDRAM_TG_ERRLOG_EN
      err_addr <= '0;
      err_exp  <= '0;
      err_act  <= '0;
`endif
    end else begin
      if (miscmp) begin
        err_cnt <= sat_inc(err_cnt);
`ifdef SDRAM_TG_ERRLOG_EN
        if (err_cnt == 16'd0) begin
          err_addr <= addr_pipe[RD_LAT-1];
          err_exp  <= exp_pipe[RD_LAT-1];
          err_act  <= rdata;
        end
`endif
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_WRITE;
            busy     <= 1'b1;
            done     <= 1'b0;
            err_cnt  <= '0;
            mode_r   <= mode;
            idx      <= '0;
            lfsr     <= SEED;
            wreq     <= 1'b1;
            waddr    <= BASE_ADDR;
            wdata    <= pattern(mode, 32'd0, SEED);
`ifdef SDRAM_TG_ERRLOG_EN
            err_addr <= '0;
            err_exp  <= '0;
            err_act  <= '0;
`endif
          end
        end

        S_WRITE: begin
          if (w_xfer) begin
            if (last_word) begin
              state <= S_READ;
              wreq  <= 1'b0;
              rreq  <= 1'b1;
              raddr <= BASE_ADDR;
              idx   <= '0;
              lfsr  <= SEED;
              rexp  <= pattern(mode_r, 32'd0, SEED);
            end else begin
              idx   <= idx_nxt;
              lfsr  <= lfsr_nxt;
              waddr <= waddr + AW'(1);
              wdata <= data_nxt;
            end
          end
        end

        S_READ: begin
          if (r_xfer) begin
            if (last_word) begin
              state <= S_DRAIN;
              rreq  <= 1'b0;
            end else begin
              idx   <= idx_nxt;
              lfsr  <= lfsr_nxt;
              raddr <= raddr + AW'(1);
              rexp  <= data_nxt;
            end
          end
        end

        S_DRAIN: begin
          // The tail entry is compared on this same edge, so finish once the head is clear.
          if (!head_busy) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
